button_event_detector: RTL
==========================

# button_event_detector

Parametrised multi-channel push-button front end with debounce and gesture classification. Each channel synchronises a raw button input, debounces it, and classifies presses into single-cycle short-press, long-press, double-press and auto-repeat events. It sits between the board pins and the control FSMs, and replaces single-channel long-press detection.

## Interface
- `CHANNELS`, 4: number of independent button channels (≥1).
- `CLK_PERIOD_ns`, 20: clock period.
- `ACTIVE_LOW`, 1: 1 means a pressed button drives the pin low; 0 means pressed drives it high.
- `DEBOUNCE_ns`, 10_000_000: stable time required before a level change is accepted.
- `LONG_ns`, 500_000_000: hold time that classifies a press as long.
- `DOUBLE_ns`, 250_000_000: maximum release-to-press gap for a double press.
- `REPEAT_ns`, 100_000_000: auto-repeat period after a long press; 0 disables repeat.
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  synchronous; when low, every channel FSM is held in IDLE, timers are cleared and event outputs are 0. Debounce keeps running.
- `btn_in`  in  CHANNELS  raw asynchronous button pins.
- `btn_level`  out  CHANNELS  debounced pressed level (1 = pressed).
- `short_press`  out  CHANNELS  1-cycle pulse per classified short press.
- `long_press`  out  CHANNELS  1-cycle pulse when the hold reaches LONG.
- `double_press`  out  CHANNELS  1-cycle pulse on a second press inside the gap window.
- `repeat_press`  out  CHANNELS  1-cycle pulse every REPEAT period while held after long.

## Operation
- Cycle constants: `DEB_CYC`, `LONG_CYC`, `DBL_CYC` and `REP_CYC` each equal the corresponding `*_ns / CLK_PERIOD_ns` (integer division). `DEB_CYC`, `LONG_CYC` and `DBL_CYC` must be ≥1; elaboration is fatal otherwise.
- Counter width is `$clog2(max(LONG_CYC, DBL_CYC, REP_CYC)+1)`. The debounce counter is sized separately. Counters saturate and never wrap.
- Per channel:
  - A 2-FF synchroniser feeds polarity correction (`ACTIVE_LOW`).
  - The debouncer loads the new value into `btn_level` once the corrected input has differed from `btn_level` for `DEB_CYC` consecutive cycles. Any return to the old value clears the count.
- FSM, driven by debounced press/release edges of `btn_level`:
  - IDLE: on press, go to PRESS and clear the timer.
  - PRESS: the timer counts. When the timer reaches `LONG_CYC`, pulse `long_press`, go to HOLD and clear the timer. On release before that, go to GAP and clear the timer.
  - HOLD: if `REP_CYC>0`, pulse `repeat_press` every `REP_CYC` cycles. On release, go to IDLE. No short event is produced.
  - GAP: on press before the timer reaches `DBL_CYC`, pulse `double_press` and go to SECOND. When the timer reaches `DBL_CYC`, pulse `short_press` and go to IDLE.
  - SECOND: on release, go to IDLE. No long or repeat events are produced in this state.
- Simultaneous events in GAP: a press on the expiry cycle wins, so `double_press` fires and `short_press` does not.
- At most one event output per channel is high in any cycle. Channels are fully independent.
- Deasserting `enable` mid-gesture returns the FSM to IDLE without any pulse.
- Reasserting `enable` while `btn_level`=1 does not start a press; a fresh press edge is required.

## Timing
- Reset values: all outputs 0, FSMs in IDLE, counters 0, and synchroniser and `btn_level` at the unpressed level.
- Reset mid-gesture aborts immediately and suppresses all pulses.
- `btn_level` changes `2+DEB_CYC` cycles after a clean pin edge.
- `long_press` is asserted `LONG_CYC` cycles after the `btn_level` rise.
- `short_press` is asserted `DBL_CYC` cycles after the `btn_level` fall.
- `double_press` is asserted 1 cycle after the second `btn_level` rise.
- `repeat_press` first fires `REP_CYC` cycles after `long_press`, then every `REP_CYC` cycles.
- All outputs are registered.

## Structure
- Package `button_event_pkg` holds:
  - the state enum (IDLE, PRESS, HOLD, GAP, SECOND);
  - the function `ns_to_cycles(ns, period)`;
  - the function `cnt_width(max)`.
- Sub-module `button_event_channel` contains the synchroniser, debouncer, FSM and timer for one channel.
- The top level generate-instantiates `CHANNELS` copies and handles `enable` fan-out.

## Test plan
Parameters: `CLK_PERIOD_ns`=20, `DEBOUNCE_ns`=100 (5 cycles), `LONG_ns`=2000 (100), `DOUBLE_ns`=1000 (50), `REPEAT_ns`=400 (20), `ACTIVE_LOW`=1.

- **Bounce:** ch0 pin toggles every 3 cycles for 30 cycles, then holds low. Expect `btn_level[0]` to rise exactly 7 cycles after the final edge and no event pulses during bouncing.
- **Short press:** press 40 cycles (debounced), then release. Expect `short_press[0]` once, 50 cycles after the `btn_level` fall, and no other events.
- **Long press with repeat:** hold 200 cycles. Expect `long_press` at 100 cycles, `repeat_press` at 120, 140, …, 200 while held, and no `short_press` after release.
- **Double press and boundary:** second press whose `btn_level` rise lands on gap cycle 49 gives `double_press` only. A rise on cycle 50 (the expiry cycle) also gives `double_press` only. A rise on cycle 51 gives `short_press` at 50, then a new PRESS.
- **Channel independence:** ch1 long press overlaps ch2 double press and ch3 short press. Expect each event on its own bit with correct timing and no crosstalk.
- **Abort:**
  - `resetn` low mid-PRESS: all outputs are 0 immediately and no pulse follows.
  - `enable` low during GAP: no `short_press`.
  - `enable` reasserted while held: no `long_press`.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared types and elaboration helpers for the multi-channel button event detector.
package button_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    HOLD,
    GAP,
    SECOND
  } state_e;

  function automatic int unsigned ns_to_cycles(input int unsigned ns, input int unsigned period);
    return ns / period;
  endfunction

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : int'($clog2(max_val + 1));
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_event_channel.sv
// One button channel: 2-FF synchroniser, debouncer and gesture classifier FSM.
//   state  | meaning
//   IDLE   | released, waiting for a debounced press edge
//   PRESS  | first press held, timing towards long
//   HOLD   | long press reached, emitting repeats while held
//   GAP    | released after a short hold, waiting for a second press
//   SECOND | second press of a double held, waiting for release
module button_event_channel
  import button_event_pkg::*;
#(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned DEB_CYC    = 1,
  parameter int unsigned LONG_CYC   = 1,
  parameter int unsigned DBL_CYC    = 1,
  parameter int unsigned REP_CYC    = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic btn_in,
  output logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_press
);

  localparam int unsigned TW     = cnt_width(max3(LONG_CYC, DBL_CYC, REP_CYC));
  localparam int unsigned DW     = cnt_width(DEB_CYC);
  localparam bit          REP_EN = (REP_CYC > 0);

  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_deb_cnt;
  logic          r_level;
  logic          r_prev;
  state_e        r_state;
  logic [TW-1:0] r_tmr;
  logic          r_short;
  logic          r_long;
  logic          r_double;
  logic          r_repeat;

  logic          w_pressed;
  logic          w_rise;
  logic          w_fall;
  logic [TW-1:0] w_tmr_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_deb_cnt <= '0;
      r_level   <= 1'b0;
    end else if (w_pressed != r_level) begin
      if (r_deb_cnt >= DW'(DEB_CYC - 1)) begin
        r_level   <= w_pressed;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end else begin
      r_deb_cnt <= '0;
    end
  end

  assign w_rise    = r_level & ~r_prev;
  assign w_fall    = ~r_level & r_prev;
  assign w_tmr_nxt = (&r_tmr) ? r_tmr : r_tmr + 1'b1;

  // The FSM sees a level edge one cycle late, so on entering PRESS/GAP the
  // timer starts at 1 to keep long/short aligned to the btn_level edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_tmr    <= '0;
      r_prev   <= 1'b0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_prev   <= r_level;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_repeat <= 1'b0;
      if (!enable) begin
        r_state <= IDLE;
        r_tmr   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise) begin
              r_state <= PRESS;
              r_tmr   <= TW'(1);
            end
          end
          PRESS: begin
            if (w_fall) begin
              r_state <= GAP;
              r_tmr   <= TW'(1);
            end else if (w_tmr_nxt >= TW'(LONG_CYC)) begin
              r_long  <= 1'b1;
              r_state <= HOLD;
              r_tmr   <= '0;
            end else begin
              r_tmr <= w_tmr_nxt;
            end
          end
          HOLD: begin
            if (w_fall) begin
              r_state <= IDLE;
              r_tmr   <= '0;
            end else if (REP_EN && (w_tmr_nxt >= TW'(REP_CYC))) begin
              r_repeat <= 1'b1;
              r_tmr    <= '0;
            end else begin
              r_tmr <= w_tmr_nxt;
            end
          end
          GAP: begin
            // A press seen on the expiry cycle takes priority over the short.
            if (w_rise) begin
              r_double <= 1'b1;
              r_state  <= SECOND;
              r_tmr    <= '0;
            end else if (w_tmr_nxt >= TW'(DBL_CYC)) begin
              r_short <= 1'b1;
              r_state <= IDLE;
              r_tmr   <= '0;
            end else begin
              r_tmr <= w_tmr_nxt;
            end
          end
          SECOND: begin
            if (w_fall) begin
              r_state <= IDLE;
              r_tmr   <= '0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_tmr   <= '0;
          end
        endcase
      end
    end
  end

  assign btn_level    = r_level;
  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_press = r_double;
  assign repeat_press = r_repeat;

endmodule

// File: rtl/button_event_detector.sv
// Multi-channel push-button front end: per-channel debounce and gesture events.
module button_event_detector
  import button_event_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned CLK_PERIOD_ns = 20,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned DEBOUNCE_ns   = 10_000_000,
  parameter int unsigned LONG_ns       = 500_000_000,
  parameter int unsigned DOUBLE_ns     = 250_000_000,
  parameter int unsigned REPEAT_ns     = 100_000_000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] short_press,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] double_press,
  output logic [CHANNELS-1:0] repeat_press
);

  localparam int unsigned DEB_CYC  = ns_to_cycles(DEBOUNCE_ns, CLK_PERIOD_ns);
  localparam int unsigned LONG_CYC = ns_to_cycles(LONG_ns, CLK_PERIOD_ns);
  localparam int unsigned DBL_CYC  = ns_to_cycles(DOUBLE_ns, CLK_PERIOD_ns);
  localparam int unsigned REP_CYC  = ns_to_cycles(REPEAT_ns, CLK_PERIOD_ns);

  if (DEB_CYC < 1 || LONG_CYC < 1 || DBL_CYC < 1) begin : g_bad_cfg
    $fatal(1, "button_event_detector: debounce, long and double windows must be at least one clock");
  end

  logic w_enable;
  assign w_enable = enable;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_event_channel #(
      .ACTIVE_LOW (ACTIVE_LOW),
      .DEB_CYC    (DEB_CYC),
      .LONG_CYC   (LONG_CYC),
      .DBL_CYC    (DBL_CYC),
      .REP_CYC    (REP_CYC)
    ) u_ch (
      .clk          (clk),
      .resetn       (resetn),
      .enable       (w_enable),
      .btn_in       (btn_in[g]),
      .btn_level    (btn_level[g]),
      .short_press  (short_press[g]),
      .long_press   (long_press[g]),
      .double_press (double_press[g]),
      .repeat_press (repeat_press[g])
    );
  end

endmodule
